fpu_div: RTL and testbench
==========================

// Module: fpu_div
// PURPOSE
//   Iterative single-precision (IEEE-754 binary32 layout) divider, result = a / b.
//   Inverse companion to the team's combinational FP32 multiplier, with the same numeric model:
//   normal operands only, truncated mantissa, no rounding.
//   Multicycle restoring division with a start/busy/done handshake.
//   Sits beside the multiplier in the FPU test datapath.
// PARAMETERS
//   EXP_W   8    exponent field width
//   MANT_W  23   stored mantissa width (hidden 1 added internally)
//   BIAS    127  exponent bias
// PORTS
//   clk           in   1   single clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   start         in   1   request; sampled only in IDLE
//   a             in   32  dividend, sampled on the accepting edge
//   b             in   32  divisor, sampled on the accepting edge
//   busy          out  1   high while a division is in flight (DIV, NORM)
//   done          out  1   one-cycle pulse; result/div_by_zero valid
//   result        out  32  quotient; held until the next completion
//   div_by_zero   out  1   qualifies result when done=1; held with result
// BEHAVIOUR
//   - Reset (async): state=IDLE; busy, done, result, div_by_zero all 0. Applies immediately, including mid-division; the in-flight operation is discarded.
//   - States:
//     IDLE -> DIV on start=1.
//     DIV loops 25 cycles, then -> NORM.
//     NORM -> IDLE after 1 cycle.
//   - Accept edge E0 (IDLE, start=1):
//     latch sign=a[31]^b[31], exp_a, exp_b;
//     rem={1,a[22:0]}; dvs={1,b[22:0]};
//     q=0; cnt=0; busy<=1.
//   - DIV, edges E1..E25: one quotient bit per edge, MSB first (q[24] down to q[0]).
//     If rem>=dvs: bit=1, rem=(rem-dvs)<<1; else bit=0, rem=rem<<1.
//     Remainder register is 25 bits wide. Last bit at E25, then -> NORM.
//     Net effect: q = floor({1,ma}*2^24 / {1,mb}).
//   - NORM, edge E26: result registered, done<=1, busy<=0, -> IDLE.
//     done is high for exactly the cycle after E26.
//     Latency: 26 clocks from accept edge to done. Throughput: one op per 26 clocks.
//   - Normalisation:
//     q[24]=1 -> mant=q[23:1], exp=exp_a-exp_b+BIAS.
//     q[24]=0 -> mant=q[22:0], exp=exp_a-exp_b+BIAS-1.
//     Exponent arithmetic is 8-bit and wraps modulo 256; no overflow or underflow detection.
//   - Special cases (exponent field 0 is treated as zero; no denormal support):
//     exp_b==0, exp_a!=0 -> {sign,8'hFF,23'h0}, div_by_zero=1.
//     exp_a==0, exp_b!=0 -> {sign,31'h0}, div_by_zero=0.
//     both exponents 0    -> 32'h7FC00000, div_by_zero=1.
//     Special cases take the same 26-cycle latency; no early exit.
//   - Handshake:
//     start while busy=1 is ignored (no queueing), and a/b changes during busy have no effect.
//     start in the same cycle that done is high is accepted (state is IDLE), giving back-to-back operation.
//     start held high continuously restarts on every IDLE cycle.
//   - done and div_by_zero never assert outside NORM->IDLE; div_by_zero clears on the next completion.
// STRUCTURE
//   - Package fpu_pkg:
//     FP32 field widths (EXP_W, MANT_W), BIAS, QNAN=32'h7FC00000, POS_INF=32'h7F800000;
//     typedef for state enum {IDLE, DIV, NORM}.
//   - One sub-module, fpu_div_step: combinational single restoring step (rem,dvs -> rem_next, qbit).
//     The top level holds the FSM, counter, operand registers and normaliser.
// TESTING
//   - 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, div_by_zero=0, done exactly 26 clocks after the accept edge.
//   - 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, q[24]=0 path).
//     0xBFC00000 / 0x3F000000 (-1.5/0.5) -> 0xC0400000.
//   - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
//     0x00000000 / 0x00000000 -> 0x7FC00000, div_by_zero=1.
//     0x00000000 / 0x40000000 -> 0x00000000, div_by_zero=0.
//   - start pulsed again at cycle 10 of an op with different a/b -> ignored; first result unchanged.
//     start asserted in the done cycle -> second op accepted; its done arrives 26 clocks later.
//   - rst asserted at cycle 12 of an op -> busy, done, result, div_by_zero go 0 immediately; no done pulse follows.
//     A new start after release completes normally.
//   - Randomised normal operands vs. a truncating reference model (a/b); bit-exact compare on every done pulse.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field widths, constants and divider FSM states
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_e;

endpackage

// File: rtl/fpu_div_step.sv
// rtl/fpu_div_step.sv - one combinational restoring-division step
module fpu_div_step #(
    parameter int MANT_W = 23
) (
    input  logic [MANT_W+1:0] rem_i,
    input  logic [MANT_W:0]   dvs_i,
    output logic [MANT_W+1:0] rem_o,
    output logic              qbit_o
);

    logic [MANT_W:0] diff;

    // rem < 2*dvs always holds, so a successful subtraction fits in MANT_W+1 bits.
    assign qbit_o = rem_i >= {1'b0, dvs_i};
    assign diff   = rem_i[MANT_W:0] - dvs_i;
    assign rem_o  = qbit_o ? {diff, 1'b0} : {rem_i[MANT_W:0], 1'b0};

endmodule

// File: rtl/fpu_div.sv
// rtl/fpu_div.sv - iterative FP32 restoring divider with start/busy/done handshake
module fpu_div
    import fpu_pkg::*;
#(
    parameter int EXP_W  = fpu_pkg::EXP_W,
    parameter int MANT_W = fpu_pkg::MANT_W,
    parameter int BIAS   = fpu_pkg::BIAS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [EXP_W+MANT_W:0]   a,
    input  logic [EXP_W+MANT_W:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    div_by_zero
);

    localparam int W     = EXP_W + MANT_W + 1;
    localparam int NQ    = MANT_W + 2;
    localparam int CNT_W = $clog2(NQ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NQ - 1);

    state_e              state_q, state_d;
    logic                sign_q;
    logic [EXP_W-1:0]    exp_a_q, exp_b_q;
    logic [MANT_W+1:0]   rem_q, rem_next;
    logic [MANT_W:0]     dvs_q;
    logic [NQ-1:0]       q_q;
    logic                qbit;
    logic [CNT_W-1:0]    cnt_q;
    logic                done_q, dbz_q, dbz_d;
    logic [W-1:0]        result_q, result_d;
    logic [EXP_W-1:0]    exp_base, exp_norm;
    logic [MANT_W-1:0]   mant_norm;
    logic                a_zero, b_zero;

    fpu_div_step #(.MANT_W(MANT_W)) u_step (
        .rem_i  (rem_q),
        .dvs_i  (dvs_q),
        .rem_o  (rem_next),
        .qbit_o (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DIV;
            DIV:     if (cnt_q == CNT_LAST) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Normaliser and special-case selection, consumed on the NORM edge.
    always_comb begin
        exp_base = exp_a_q - exp_b_q + EXP_W'(BIAS);
        if (q_q[NQ-1]) begin
            mant_norm = q_q[NQ-2:1];
            exp_norm  = exp_base;
        end else begin
            mant_norm = q_q[NQ-3:0];
            exp_norm  = exp_base - EXP_W'(1);
        end
        a_zero   = (exp_a_q == '0);
        b_zero   = (exp_b_q == '0);
        result_d = {sign_q, exp_norm, mant_norm};
        dbz_d    = 1'b0;
        if (a_zero && b_zero) begin
            result_d = W'(QNAN);
            dbz_d    = 1'b1;
        end else if (b_zero) begin
            result_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            dbz_d    = 1'b1;
        end else if (a_zero) begin
            result_d = {sign_q, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q   <= 1'b0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= a[W-1] ^ b[W-1];
                        exp_a_q <= a[W-2:MANT_W];
                        exp_b_q <= b[W-2:MANT_W];
                        rem_q   <= {2'b01, a[MANT_W-1:0]};
                        dvs_q   <= {1'b1, b[MANT_W-1:0]};
                        q_q     <= '0;
                        cnt_q   <= '0;
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    q_q   <= {q_q[NQ-2:0], qbit};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                NORM: begin
                    result_q <= result_d;
                    dbz_q    <= dbz_d;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpu_div.sv
// tb/tb_fpu_div.sv - scoreboard-driven self-checking bench for fpu_div
module tb_fpu_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    typedef struct packed {
        logic [31:0] res;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass     = 0;
    int   n_total    = 0;
    int   done_count = 0;

    always #5 clk = ~clk;

    fpu_div dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always @(negedge clk) if (done === 1'b1) done_count++;

    // Reference: direct wide integer division of the significands, then truncate.
    function automatic exp_t ref_div(input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        logic [7:0]  ea, eb, e;
        logic        s;
        logic [47:0] num, den, q;
        ea = x[30:23];
        eb = y[30:23];
        s  = x[31] ^ y[31];
        if (ea == 8'd0 && eb == 8'd0) begin
            r.res = 32'h7FC00000; r.dbz = 1'b1;
        end else if (eb == 8'd0) begin
            r.res = {s, 8'hFF, 23'h0}; r.dbz = 1'b1;
        end else if (ea == 8'd0) begin
            r.res = {s, 31'h0}; r.dbz = 1'b0;
        end else begin
            num = {24'h0, 1'b1, x[22:0]} << 24;
            den = {24'h0, 1'b1, y[22:0]};
            q   = num / den;
            if (q[24]) begin
                e = ea - eb + 8'd127;
                r.res = {s, e, q[23:1]};
            end else begin
                e = ea - eb + 8'd126;
                r.res = {s, e, q[22:0]};
            end
            r.dbz = 1'b0;
        end
        return r;
    endfunction

    // Call at #1 after a rising edge with the DUT idle (or in its done cycle).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          output logic [31:0] r, output logic z, output int cyc);
        sb_q.push_back(ref_div(ta, tb));
        a = ta; b = tb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = result;
        z = div_by_zero;
    endtask

    task automatic test_reset;
        n_total++;
        if ({busy, done, result, div_by_zero} !== 35'h0)
            $display("FAIL reset_state: got busy=%b done=%b result=%h dbz=%b required all 0",
                     busy, done, result, div_by_zero);
        else n_pass++;
    endtask

    task automatic test_directed;
        logic [31:0] ta [6] = '{32'h40C00000, 32'h3F800000, 32'hBFC00000,
                                32'h3F800000, 32'h00000000, 32'h00000000};
        logic [31:0] tb [6] = '{32'h40000000, 32'h40400000, 32'h3F000000,
                                32'h00000000, 32'h00000000, 32'h40000000};
        logic [31:0] er [6] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000,
                                32'h7F800000, 32'h7FC00000, 32'h00000000};
        logic        ez [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] r;
        logic        z;
        int          cyc;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], r, z, cyc);
            e = sb_q.pop_front();
            n_total++;
            if (cyc !== 26) $display("FAIL directed_latency[%0d]: got %0d clocks required 26", i, cyc);
            else n_pass++;
            n_total++;
            if (r !== er[i] || z !== ez[i])
                $display("FAIL directed_result[%0d]: got %h dbz=%b required %h dbz=%b", i, r, z, er[i], ez[i]);
            else n_pass++;
            n_total++;
            if (r !== e.res || z !== e.dbz)
                $display("FAIL directed_model[%0d]: got %h dbz=%b required %h dbz=%b", i, r, z, e.res, e.dbz);
            else n_pass++;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int   cyc, dc0;
        dc0 = done_count;
        sb_q.push_back(ref_div(32'h40C00000, 32'h40000000));
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL ignore_busy: got %b required 1", busy);
        else n_pass++;
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'h0; b = 32'h0;
        cyc = 11;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        n_total++;
        if (cyc !== 26) $display("FAIL ignore_latency: got %0d clocks required 26", cyc);
        else n_pass++;
        n_total++;
        if (result !== e.res || div_by_zero !== e.dbz)
            $display("FAIL ignore_result: got %h dbz=%b required %h dbz=%b", result, div_by_zero, e.res, e.dbz);
        else n_pass++;
        repeat (35) @(posedge clk);
        #1;
        n_total++;
        if (done_count - dc0 !== 1) $display("FAIL ignore_pulses: got %0d done pulses required 1", done_count - dc0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic        z;
        int          cyc;
        exp_t        e;
        run_op(32'h3F800000, 32'h40400000, r, z, cyc);
        e = sb_q.pop_front();
        n_total++;
        if (cyc !== 26 || r !== e.res) $display("FAIL b2b_first: got %h after %0d required %h after 26", r, cyc, e.res);
        else n_pass++;
        run_op(32'hBFC00000, 32'h3F000000, r, z, cyc);
        e = sb_q.pop_front();
        n_total++;
        if (cyc !== 26) $display("FAIL b2b_latency: got %0d clocks required 26", cyc);
        else n_pass++;
        n_total++;
        if (r !== e.res || z !== e.dbz) $display("FAIL b2b_result: got %h dbz=%b required %h dbz=%b", r, z, e.res, e.dbz);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        logic        z;
        int          cyc, dc0;
        exp_t        e;
        sb_q.push_back(ref_div(32'h3F800000, 32'h40400000));
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        void'(sb_q.pop_back());
        n_total++;
        if ({busy, done, result, div_by_zero} !== 35'h0)
            $display("FAIL midreset_state: got busy=%b done=%b result=%h dbz=%b required all 0",
                     busy, done, result, div_by_zero);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        dc0 = done_count;
        repeat (40) @(posedge clk);
        #1;
        n_total++;
        if (done_count !== dc0) $display("FAIL midreset_no_done: got %0d pulses required 0", done_count - dc0);
        else n_pass++;
        run_op(32'h40C00000, 32'h40000000, r, z, cyc);
        e = sb_q.pop_front();
        n_total++;
        if (cyc !== 26 || r !== e.res || z !== e.dbz)
            $display("FAIL midreset_recover: got %h dbz=%b after %0d required %h dbz=%b after 26",
                     r, z, cyc, e.res, e.dbz);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [31:0] ta, tb, r;
        logic        z;
        int          cyc;
        exp_t        e;
        for (int i = 0; i < 40; i++) begin
            ta = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            tb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op(ta, tb, r, z, cyc);
            e = sb_q.pop_front();
            n_total++;
            if (cyc !== 26 || r !== e.res || z !== e.dbz)
                $display("FAIL random[%0d] %h/%h: got %h dbz=%b after %0d required %h dbz=%b after 26",
                         i, ta, tb, r, z, cyc, e.res, e.dbz);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_total++;
        if (sb_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
